// File: rtl/pc_return_stack_pkg.sv
// Shared definitions for the MUSA IF-stage return-address stack.
package pc_return_stack_pkg;

  localparam int MUSA_DATA_WIDTH = 32;

  // PC-select mux sources; the stack's top feeds the PILHA input.
  typedef enum logic [1:0] {
    PCSRC_PILHA     = 2'b00,
    PCSRC_REGISTERS = 2'b01,
    PCSRC_RELATIVE  = 2'b10
  } pcsrc_e;

  // One stack request per cycle.
  typedef struct packed {
    logic flush;
    logic push;
    logic pop;
  } rs_req_t;

  // Operation after priority resolution (flush beats push/pop).
  typedef enum logic [2:0] {
    RS_IDLE,
    RS_PUSH,
    RS_POP,
    RS_REPLACE,
    RS_FLUSH
  } rs_op_e;

  function automatic rs_op_e rs_decode(input rs_req_t req);
    if (req.flush)                rs_decode = RS_FLUSH;
    else if (req.push && req.pop) rs_decode = RS_REPLACE;
    else if (req.push)            rs_decode = RS_PUSH;
    else if (req.pop)             rs_decode = RS_POP;
    else                          rs_decode = RS_IDLE;
  endfunction

endpackage

// File: rtl/pc_return_stack_mem.sv
// Return-stack storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; occupancy tracking lives in the parent.
module pc_return_stack_mem
  import pc_return_stack_pkg::*;
#(
  parameter int DATA_WIDTH = MUSA_DATA_WIDTH,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_return_stack.sv
// Hardware return-address stack for the IF stage. CALL pushes, RET pops.
// top is registered so the PILHA mux input never depends combinationally on
// this cycle's request. Overflow/underflow are sticky until err_clr.
module pc_return_stack
  import pc_return_stack_pkg::*;
#(
  parameter int DATA_WIDTH = MUSA_DATA_WIDTH,
  parameter int DEPTH      = 16,
  localparam int CNT_W     = $clog2(DEPTH+1),
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_addr,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] top,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  rs_req_t               req;
  rs_op_e                op;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [AW-1:0]         raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic [CNT_W-1:0]      count_n;
  logic [DATA_WIDTH-1:0] top_n;
  logic                  ovf_set;
  logic                  unf_set;

  assign req   = '{flush: flush, push: push, pop: pop};
  assign op    = rs_decode(req);
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // Entry below the top becomes the new top on a pop; only meaningful when count>=2.
  assign raddr = AW'(count - CNT_TWO);

  pc_return_stack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_addr),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Next occupancy, top, write strobe and error events for this cycle's request.
  always_comb begin
    we      = 1'b0;
    waddr   = AW'(count);
    count_n = count;
    top_n   = top;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (op)
      RS_FLUSH: begin
        count_n = '0;
        top_n   = '0;
      end
      RS_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          we      = 1'b1;
          count_n = count + CNT_ONE;
          top_n   = push_addr;
        end
      end
      RS_POP: begin
        if (empty) begin
          unf_set = 1'b1;
        end else if (count == CNT_ONE) begin
          count_n = '0;
          top_n   = '0;
        end else begin
          count_n = count - CNT_ONE;
          top_n   = rdata;
        end
      end
      RS_REPLACE: begin
        // Overwrite the top in place; an empty stack degrades to a plain push.
        we    = 1'b1;
        top_n = push_addr;
        if (empty) begin
          waddr   = '0;
          count_n = CNT_ONE;
          unf_set = 1'b1;
        end else begin
          waddr = AW'(count - CNT_ONE);
        end
      end
      default: ;
    endcase
  end

  // Occupancy, top and sticky flags; an error event outranks err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      top       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_n;
      top       <= top_n;
      overflow  <= ovf_set | (overflow  & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
    end
  end

endmodule
